// File: rtl/img_pkg.sv
// Shared definitions for the image front end (frame loader and classifier).
//   IMG_DIM / IMG_PIXELS : frame geometry (28x28 = 784 binary pixels)
//   PIX_PER_WR           : pixels carried per accepted byte
//   state_t              : loader FSM states
//   frame_t              : one binary frame, bit index = row*IMG_DIM + col
// Optional macro IMG_PACKED_INPUT_EN: each byte carries 8 pre-binarized pixels.
package img_pkg;

    localparam int IMG_DIM    = 28;
    localparam int IMG_PIXELS = IMG_DIM * IMG_DIM;

`ifdef IMG_PACKED_INPUT_EN
    localparam int PIX_PER_WR = 8;
`else
    localparam int PIX_PER_WR = 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    typedef logic [IMG_PIXELS-1:0] frame_t;

endpackage

// File: rtl/img_frame_loader_pixel_binarizer.sv
// pixel_binarizer: turns one host byte into the pixel bits it represents.
//   data_in : host byte
//   pix     : PIX_PER_WR binary pixels, pix[0] is the lowest frame index
// Grayscale build: pix = (data_in >= THRESHOLD), unsigned compare.
// IMG_PACKED_INPUT_EN build: the byte is already 8 binary pixels, passed through.
module pixel_binarizer
    import img_pkg::*;
#(
    parameter logic [7:0] THRESHOLD = 8'd128
) (
    input  logic [7:0]            data_in,
    output logic [PIX_PER_WR-1:0] pix
);

`ifdef IMG_PACKED_INPUT_EN
    assign pix = data_in;
`else
    assign pix = (data_in >= THRESHOLD);
`endif

endmodule

// File: rtl/img_frame_loader.sv
// img_frame_loader: assembles a 28x28 binary frame from a host byte stream and
// hands it to the classifier with a valid/consume handshake.
//   clk, reset (async, active low)
//   data_in, write_enable, sof : host byte stream, sof marks pixel 0
//   img_bits, img_valid         : completed frame, held until img_consume
//   img_consume                 : classifier took the frame (pulse)
//   pix_count                   : pixels accepted in the current frame
//   busy                        : frame partially loaded
//   overflow                    : sticky, a write arrived while a frame was pending
// Optional macro IMG_PACKED_INPUT_EN: 8 pre-binarized pixels per byte, 98 bytes/frame.
module img_frame_loader #(
    parameter int         IMG_DIM   = 28,
    parameter logic [7:0] THRESHOLD = 8'd128,
    parameter int         CNT_W     = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   data_in,
    input  logic                         write_enable,
    input  logic                         sof,
    output logic [IMG_DIM*IMG_DIM-1:0]   img_bits,
    output logic                         img_valid,
    input  logic                         img_consume,
    output logic [CNT_W-1:0]             pix_count,
    output logic                         busy,
    output logic                         overflow
);
    import img_pkg::*;

    localparam int NPIX = IMG_DIM * IMG_DIM;

    state_t                   state, state_nxt;
    logic [PIX_PER_WR-1:0]    pix;
    logic [CNT_W-1:0]         cnt_inc;
    logic [NPIX-1:0]          fresh_frame;
    logic                     restart;

    pixel_binarizer #(.THRESHOLD(THRESHOLD)) u_bin (
        .data_in (data_in),
        .pix     (pix)
    );

    assign cnt_inc     = pix_count + CNT_W'(PIX_PER_WR);
    // A new frame starts with every other position cleared.
    assign fresh_frame = NPIX'(pix);
    // First write out of IDLE, or a resync in LOAD, starts over at pixel 0.
    assign restart     = (state == IDLE) || sof;

    assign img_valid = (state == FULL);
    assign busy      = (state == LOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (write_enable) state_nxt = LOAD;
            LOAD: if (write_enable && !sof && cnt_inc == CNT_W'(NPIX)) state_nxt = FULL;
            FULL: if (img_consume) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            img_bits  <= '0;
            pix_count <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (write_enable) begin
                        if (restart) begin
                            img_bits  <= fresh_frame;
                            pix_count <= CNT_W'(PIX_PER_WR);
                        end else begin
                            img_bits[pix_count +: PIX_PER_WR] <= pix;
                            pix_count <= cnt_inc;
                        end
                    end
                end
                FULL: begin
                    // Frame is held; any write is dropped and flagged.
                    if (write_enable) overflow <= 1'b1;
                    if (img_consume)  pix_count <= '0;
                end
                default: pix_count <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_img_frame_loader.sv
// Self-checking bench for img_frame_loader: directed scenarios plus a random
// phase, every cycle compared against a frame-level reference model.
module tb_img_frame_loader;

`ifdef IMG_PACKED_INPUT_EN
    localparam int P = 8;
`else
    localparam int P = 1;
`endif
    localparam int NPIX = 784;
    localparam int WPF  = NPIX / P;   // writes per frame

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [7:0]     data_in = '0;
    logic           write_enable = 1'b0;
    logic           sof = 1'b0;
    logic [NPIX-1:0] img_bits;
    logic           img_valid;
    logic           img_consume = 1'b0;
    logic [9:0]     pix_count;
    logic           busy;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [NPIX-1:0] m_bits;
    int              m_cnt;
    bit              m_full;
    bit              m_ovf;

    img_frame_loader dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write_enable (write_enable),
        .sof          (sof),
        .img_bits     (img_bits),
        .img_valid    (img_valid),
        .img_consume  (img_consume),
        .pix_count    (pix_count),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [NPIX-1:0] got, input logic [NPIX-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pixels_of(input logic [7:0] d);
`ifdef IMG_PACKED_INPUT_EN
        return d;
`else
        return {7'd0, (d >= 8'd128)};
`endif
    endfunction

    task automatic model_reset();
        m_bits = '0; m_cnt = 0; m_full = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit we, input logic [7:0] d, input bit s, input bit c);
        logic [7:0] px;
        px = pixels_of(d);
        if (m_full) begin
            if (we) m_ovf = 1;
            if (c) begin m_full = 0; m_cnt = 0; end
        end else if (we) begin
            if (m_cnt == 0 || s) begin m_bits = '0; m_cnt = 0; end
            for (int k = 0; k < P; k++) m_bits[m_cnt + k] = px[k];
            m_cnt += P;
            if (m_cnt == NPIX) m_full = 1;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, NPIX'(img_valid), NPIX'(m_full));
        chk({tag, ".cnt"},   NPIX'(pix_count), NPIX'(m_cnt));
        chk({tag, ".busy"},  NPIX'(busy),      NPIX'(!m_full && m_cnt != 0));
        chk({tag, ".ovf"},   NPIX'(overflow),  NPIX'(m_ovf));
        chk({tag, ".bits"},  img_bits,         m_bits);
    endtask

    task automatic step(input bit we, input logic [7:0] d, input bit s, input bit c, input string tag);
        write_enable = we; data_in = d; sof = s; img_consume = c;
        @(posedge clk); #1;
        model_step(we, d, s, c);
        chk_all(tag);
        write_enable = 0; sof = 0; img_consume = 0;
    endtask

    task automatic rand_writes(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 8'($urandom), 0, 0, tag);
    endtask

    initial begin
        logic [NPIX-1:0] alt;
        logic [3:0]      thr;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk); reset = 1'b1;

        // alternating 200/10 frame, sof on first byte
        for (int i = 0; i < WPF; i++)
            step(1, (i % 2 == 0) ? 8'd200 : 8'd10, i == 0, 0, "alt");
        alt = {392{2'b01}};
        if (P == 1) chk("alt_pattern", img_bits, alt);
        chk("alt_valid", NPIX'(img_valid), NPIX'(1));

        // writes while full are dropped
        for (int i = 0; i < 3; i++) step(1, 8'd255, i == 1, 0, "ovf");
        chk("ovf_held", img_bits, m_bits);
        step(0, 8'd0, 0, 1, "consume");
        chk("consume_ovf", NPIX'(overflow), NPIX'(1));
        chk("consume_cnt", NPIX'(pix_count), NPIX'(0));

        // threshold boundary at indices 0..3
        step(1, 8'd127, 1, 0, "thr");
        step(1, 8'd128, 0, 0, "thr");
        step(1, 8'd255, 0, 0, "thr");
        step(1, 8'd0,   0, 0, "thr");
        thr = img_bits[3:0];
        if (P == 1) chk("thr_bits", NPIX'(thr), NPIX'(4'b0110));
        rand_writes(WPF - 4, "thr_fill");
        // consume with a write in the same cycle: write dropped
        step(1, 8'd255, 1, 1, "cons_wr");

        // partial frame then resync
        rand_writes((P == 1) ? 300 : 37, "part");
        step(1, 8'd255, 1, 0, "resync");
        chk("resync_cnt", NPIX'(pix_count), NPIX'(P));
        chk("resync_bits", img_bits, NPIX'(pixels_of(8'd255)));
        rand_writes(WPF - 1, "resync_fill");
        chk("resync_full", NPIX'(img_valid), NPIX'(1));
        step(0, 8'd0, 0, 1, "consume2");

        // reset in the middle of a frame
        rand_writes((P == 1) ? 500 : 60, "pre_rst");
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk_all("mid_rst");
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < WPF; i++) step(1, 8'($urandom), i == 0, 0, "post_rst");
        chk("post_rst_full", NPIX'(img_valid), NPIX'(1));
        step(0, 8'd0, 0, 1, "consume3");

        // random traffic with gaps, resyncs and stray consumes
        for (int i = 0; i < 3000; i++) begin
            bit c;
            c = m_full ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 199) == 0, c, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
